// File: rtl/wb_master.sv
// wb_master: single-outstanding Wishbone classic master. It takes one command through a
// valid/ready handshake, runs one bus cycle with an ack timeout, and returns one response.
module wb_master #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [29:0] req_adr_i,
   input  logic [3:0]  req_sel_i,
   input  logic [31:0] req_dat_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [29:0] adr_o,
   output logic [3:0]  sel_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i
);
   // state | meaning
   // IDLE  | waiting for a command, req_ready_o high
   // BUS   | bus cycle in progress, waiting for ack_i or timeout
   // RESP  | response held until rsp_ready_i
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // counter value at the edge that ends the TIMEOUT-th unacknowledged bus cycle
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [29:0] adr_q, adr_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] dat_q, dat_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_dat_q, rsp_dat_d;
   logic        rsp_err_q, rsp_err_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      adr_d       = adr_q;
      sel_d       = sel_q;
      dat_d       = dat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               we_d    = req_we_i;
               adr_d   = req_adr_i;
               sel_d   = req_sel_i;
               dat_d   = req_dat_i;
               cyc_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_BUS;
            end
         end
         ST_BUS: begin
            if (ack_i) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = we_q ? 32'h0 : dat_i;
               rsp_err_d   = 1'b0;
               state_d     = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = 32'h0;
               rsp_err_d   = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         sel_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         sel_q       <= sel_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign cyc_o       = cyc_q;
   assign stb_o       = cyc_q;
   assign we_o        = we_q;
   assign adr_o       = adr_q;
   assign sel_o       = sel_q;
   assign dat_o       = dat_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_dat_o   = rsp_dat_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_master.sv
// tb_wb_master: directed scenarios with literal expectations plus a randomized run, all
// checked every cycle against a transaction-level model of the master.
module tb_wb_master;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [29:0] req_adr = '0;
   logic [3:0]  req_sel = '0;
   logic [31:0] req_dat = '0;
   logic        rsp_ready = 1'b0;
   logic [31:0] dat_in = '0;
   logic        ack = 1'b0;

   logic        req_ready_o, rsp_valid_o, rsp_err_o, cyc_o, stb_o, we_o;
   logic [31:0] rsp_dat_o, dat_o;
   logic [29:0] adr_o;
   logic [3:0]  sel_o;

   wb_master #(.TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
      .req_adr_i(req_adr), .req_sel_i(req_sel), .req_dat_i(req_dat),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat_o),
      .rsp_err_o(rsp_err_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
      .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_in), .ack_i(ack)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: phase 0 = waiting for command, 1 = bus cycle open, 2 = response held.
   int          ph = 0;
   int          waited = 0;
   logic        m_we = 1'b0;
   logic [29:0] m_adr = '0;
   logic [3:0]  m_sel = '0;
   logic [31:0] m_dat = '0;
   logic [31:0] m_rdat = '0;
   logic        m_err = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph = 0; waited = 0;
         m_we = 1'b0; m_adr = '0; m_sel = '0; m_dat = '0;
         m_rdat = '0; m_err = 1'b0;
      end else if (ph == 0) begin
         if (req_valid) begin
            m_we = req_we; m_adr = req_adr; m_sel = req_sel; m_dat = req_dat;
            waited = 0;
            ph = 1;
         end
      end else if (ph == 1) begin
         waited = waited + 1;
         if (ack) begin
            m_rdat = m_we ? 32'h0 : dat_in;
            m_err = 1'b0;
            ph = 2;
         end else if (waited == TO) begin
            m_rdat = 32'h0;
            m_err = 1'b1;
            ph = 2;
         end
      end else begin
         if (rsp_ready) ph = 0;
      end
   end

   bit chk_on = 1'b0;

   always @(negedge clk) begin
      if (chk_on) begin
         chk("req_ready", req_ready_o, ph == 0);
         chk("cyc", cyc_o, ph == 1);
         chk("stb", stb_o, ph == 1);
         chk("rsp_valid", rsp_valid_o, ph == 2);
         chk("we", we_o, m_we);
         chk("adr", adr_o, m_adr);
         chk("sel", sel_o, m_sel);
         chk("dat_o", dat_o, m_dat);
         if (ph == 2) begin
            chk("rsp_dat", rsp_dat_o, m_rdat);
            chk("rsp_err", rsp_err_o, m_err);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                        input logic [31:0] d);
      req_we = we; req_adr = adr; req_sel = sel; req_dat = d;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   // Runs the open bus cycle; acks during its ack_at-th cycle (0 = never). Bounded.
   task automatic run_bus(input int ack_at, input logic [31:0] d, output int ncyc);
      ncyc = 0;
      for (int i = 0; i < 40 && cyc_o; i++) begin
         ncyc++;
         ack = (ncyc == ack_at);
         dat_in = ack ? d : $urandom;
         step();
      end
      ack = 1'b0;
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("released_valid", rsp_valid_o, 1'b0);
      chk("released_ready", req_ready_o, 1'b1);
   endtask

   int          ncyc;
   logic [31:0] held_dat;
   logic        held_err;

   initial begin
      step();
      step();
      chk("rst_cyc", cyc_o, 1'b0);
      chk("rst_rsp_valid", rsp_valid_o, 1'b0);
      chk("rst_adr", adr_o, 30'h0);
      chk("rst_dat", dat_o, 32'h0);
      chk("rst_ready", req_ready_o, 1'b1);
      rst_n = 1'b1;
      chk_on = 1'b1;

      // write, acked in 3rd bus cycle
      issue(1'b1, 30'h00000004, 4'hF, 32'hDEADBEEF);
      chk("wr_cyc", cyc_o, 1'b1);
      chk("wr_adr", adr_o, 30'h00000004);
      chk("wr_sel", sel_o, 4'hF);
      chk("wr_dat", dat_o, 32'hDEADBEEF);
      chk("wr_we", we_o, 1'b1);
      run_bus(3, 32'h55AA55AA, ncyc);
      chk("wr_ncyc", ncyc, 3);
      chk("wr_rsp_valid", rsp_valid_o, 1'b1);
      chk("wr_rsp_dat", rsp_dat_o, 32'h0);
      chk("wr_rsp_err", rsp_err_o, 1'b0);

      // backpressure with spurious acks and requests
      held_dat = rsp_dat_o;
      held_err = rsp_err_o;
      for (int i = 0; i < 5; i++) begin
         ack = i[0];
         dat_in = $urandom;
         req_valid = 1'b1;
         req_adr = 30'($urandom);
         step();
         chk("bp_valid", rsp_valid_o, 1'b1);
         chk("bp_dat", rsp_dat_o, held_dat);
         chk("bp_err", rsp_err_o, held_err);
         chk("bp_ready", req_ready_o, 1'b0);
         chk("bp_cyc", cyc_o, 1'b0);
      end
      ack = 1'b0;
      req_valid = 1'b0;
      release_rsp();

      // read, acked in first bus cycle
      issue(1'b0, 30'h10, 4'h3, 32'h0);
      run_bus(1, 32'h12345678, ncyc);
      chk("rd_ncyc", ncyc, 1);
      chk("rd_rsp_dat", rsp_dat_o, 32'h12345678);
      chk("rd_rsp_err", rsp_err_o, 1'b0);
      release_rsp();

      // timeout, no ack
      issue(1'b0, 30'h20, 4'h1, 32'h0);
      run_bus(0, 32'h0, ncyc);
      chk("to_ncyc", ncyc, TO);
      chk("to_rsp_err", rsp_err_o, 1'b1);
      chk("to_rsp_dat", rsp_dat_o, 32'h0);
      release_rsp();

      // ack on the last allowed cycle beats the timeout
      issue(1'b0, 30'h24, 4'hF, 32'h0);
      run_bus(TO, 32'hCAFEF00D, ncyc);
      chk("late_ncyc", ncyc, TO);
      chk("late_rsp_err", rsp_err_o, 1'b0);
      chk("late_rsp_dat", rsp_dat_o, 32'hCAFEF00D);
      release_rsp();

      // asynchronous reset in the middle of a bus cycle
      issue(1'b1, 30'h30, 4'hC, 32'hA5A5A5A5);
      step();
      chk("mid_cyc_before", cyc_o, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_cyc_async", cyc_o, 1'b0);
      chk("mid_stb_async", stb_o, 1'b0);
      chk("mid_rsp_valid", rsp_valid_o, 1'b0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_valid", rsp_valid_o, 1'b0);
      issue(1'b0, 30'h40, 4'hF, 32'h0);
      run_bus(2, 32'h0BADF00D, ncyc);
      chk("post_rst_ncyc", ncyc, 2);
      chk("post_rst_dat", rsp_dat_o, 32'h0BADF00D);
      release_rsp();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         req_valid = ($urandom_range(0, 2) != 0);
         req_we    = 1'($urandom);
         req_adr   = 30'($urandom);
         req_sel   = 4'($urandom);
         req_dat   = $urandom;
         ack       = ($urandom_range(0, 2) == 0);
         dat_in    = $urandom;
         rsp_ready = ($urandom_range(0, 1) == 0);
         step();
      end
      req_valid = 1'b0;
      ack = 1'b0;
      rsp_ready = 1'b0;
      step();
      chk_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_master.md
WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a bus cycle may wait for ack_i before abort; legal range 1..65535.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  1  command present.
REQ-005 req_ready_o  output  1  command accepted this cycle when high with req_valid_i.
REQ-006 req_we_i  input  1  1 = write, 0 = read.
REQ-007 req_adr_i  input  30  word address [31:2].
REQ-008 req_sel_i  input  4  byte lane select.
REQ-009 req_dat_i  input  32  write data.
REQ-010 rsp_valid_o  output  1  response present.
REQ-011 rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-012 rsp_dat_o  output  32  read data; 0 for writes and timeouts.
REQ-013 rsp_err_o  output  1  1 = cycle aborted by timeout.
REQ-014 cyc_o, stb_o  output  1 each  bus cycle / strobe; always equal.
REQ-015 we_o  output  1; adr_o  output  30 [31:2]; sel_o  output  4; dat_o  output  32.
REQ-016 dat_i  input  32  read data from slave; ack_i  input  1  slave acknowledge.

Function
REQ-017 States: IDLE, BUS, RESP; exactly one active.
REQ-018 req_ready_o SHALL be 1 only in IDLE (combinational from state, not from req_valid_i).
REQ-019 IDLE, req_valid_i=1 at edge: latch we/adr/sel/dat onto bus outputs, assert cyc_o/stb_o, clear timeout counter, go BUS; first bus cycle visible the cycle after acceptance.
REQ-020 Bus outputs SHALL be registered and stable for the whole of BUS.
REQ-021 BUS, ack_i=1 at edge: deassert cyc_o/stb_o, latch rsp_dat_o = dat_i if read else 0, rsp_err_o=0, assert rsp_valid_o, go RESP; min command-to-response latency 2 cycles.
REQ-022 BUS, ack_i=0: counter increments by 1; when counter equals TIMEOUT-1 at edge: deassert cyc_o/stb_o, rsp_err_o=1, rsp_dat_o=0, go RESP (cycle aborted after exactly TIMEOUT bus cycles).
REQ-023 ack_i and timeout on same edge: ack wins, rsp_err_o=0.
REQ-024 Counter width 16 bits; SHALL never wrap within one cycle.
REQ-025 RESP: rsp_valid_o, rsp_dat_o, rsp_err_o held until rsp_ready_i=1 at edge, then rsp_valid_o=0, go IDLE; no new request accepted in that same cycle.
REQ-026 ack_i outside BUS SHALL be ignored; dat_i sampled only on accepted ack.
REQ-027 req_* inputs outside IDLE SHALL be ignored.
REQ-028 we_o/adr_o/sel_o/dat_o hold last values outside BUS (only cyc_o/stb_o qualify them).

Reset
REQ-029 rst_i=0 SHALL immediately force IDLE, cyc_o=stb_o=0, we_o=0, adr_o=0, sel_o=0, dat_o=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, counter=0.
REQ-030 Reset during BUS SHALL drop cyc_o/stb_o asynchronously; the aborted command produces no response.
REQ-031 First command accepted on first rising edge with rst_i=1 and req_valid_i=1.

Verification
REQ-032 Write: req adr=0x00000004, sel=0xF, dat=0xDEADBEEF, slave acks after 3 cycles -> bus shows same values, cyc held 3 cycles, rsp_valid_o=1, rsp_dat_o=0, rsp_err_o=0.
REQ-033 Read: adr=0x10, slave acks next cycle with dat_i=0x12345678 -> rsp_dat_o=0x12345678 two cycles after acceptance, rsp_err_o=0.
REQ-034 Timeout, TIMEOUT=4, no ack -> cyc_o high exactly 4 cycles, rsp_err_o=1, rsp_dat_o=0; ack arriving on 4th cycle -> rsp_err_o=0.
REQ-035 Backpressure: rsp_ready_i=0 for 5 cycles -> response stable, req_ready_o=0, spurious ack_i pulses ignored; release -> IDLE next cycle.
REQ-036 rst_i=0 mid-BUS -> cyc_o/stb_o low without clock edge, no rsp_valid_o; next command after reset completes normally.
